// File: rtl/otter_csr_pkg.sv
// rtl/otter_csr_pkg.sv - CSR addresses, mstatus bit positions and trap cause constants
package otter_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MCAUSE_EXT_INT = 32'h8000_000B;

    // Word-align an address; mtvec and mepc never hold the two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/intr_sync.sv
// rtl/intr_sync.sv - two-flop synchronizer with rising-edge pulse for an async level input
module intr_sync (
    input  logic clk,
    input  logic RST,
    input  logic async_in,
    output logic pulse
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - machine-mode trap entry/return and CSR file for the OTTER core
module trap_csr_unit
    import otter_csr_pkg::*;
#(
    parameter logic [31:0] MCAUSE_EXT = MCAUSE_EXT_INT
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        INTR,
    input  logic [31:0] PC,
    input  logic        INT_TAKEN,
    input  logic        MRET,
    input  logic        CSR_WE,
    input  logic [11:0] CSR_ADDR,
    input  logic [31:0] CSR_WD,
    output logic [31:0] CSR_RD,
    output logic        INT_REQ,
    output logic [31:0] MTVEC,
    output logic [31:0] MEPC
);

    logic        mie, mpie;
    logic [31:0] mtvec, mepc, mcause;
    logic        pending;
    logic        intr_edge;
    logic        unused_pc_low;

    assign unused_pc_low = ^PC[1:0];

    intr_sync u_intr_sync (
        .clk      (clk),
        .RST      (RST),
        .async_in (INTR),
        .pulse    (intr_edge)
    );

    logic wr_mstatus, wr_mtvec, wr_mepc, wr_mcause;
    assign wr_mstatus = CSR_WE && (CSR_ADDR == CSR_MSTATUS);
    assign wr_mtvec   = CSR_WE && (CSR_ADDR == CSR_MTVEC);
    assign wr_mepc    = CSR_WE && (CSR_ADDR == CSR_MEPC);
    assign wr_mcause  = CSR_WE && (CSR_ADDR == CSR_MCAUSE);

    // Priority is resolved per field, so a write to a CSR the trap does not touch still lands.
    always_ff @(posedge clk) begin
        if (RST) begin
            mie     <= 1'b0;
            mpie    <= 1'b0;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
            pending <= 1'b0;
        end else begin
            if (INT_TAKEN) begin
                mpie <= mie;
                mie  <= 1'b0;
            end else if (MRET) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (wr_mstatus) begin
                mie  <= CSR_WD[MSTATUS_MIE];
                mpie <= CSR_WD[MSTATUS_MPIE];
            end

            if (wr_mtvec)
                mtvec <= word_align(CSR_WD);

            if (INT_TAKEN)
                mepc <= word_align(PC);
            else if (wr_mepc)
                mepc <= word_align(CSR_WD);

            if (INT_TAKEN)
                mcause <= MCAUSE_EXT;
            else if (wr_mcause)
                mcause <= CSR_WD;

            // A fresh edge beats the clear so an interrupt arriving during entry is kept.
            if (intr_edge)
                pending <= 1'b1;
            else if (INT_TAKEN)
                pending <= 1'b0;
        end
    end

    logic [31:0] mstatus_rd;
    always_comb begin
        mstatus_rd               = '0;
        mstatus_rd[MSTATUS_MIE]  = mie;
        mstatus_rd[MSTATUS_MPIE] = mpie;
    end

    always_comb begin
        CSR_RD = '0;
        case (CSR_ADDR)
            CSR_MSTATUS: CSR_RD = mstatus_rd;
            CSR_MTVEC:   CSR_RD = mtvec;
            CSR_MEPC:    CSR_RD = mepc;
            CSR_MCAUSE:  CSR_RD = mcause;
            default:     CSR_RD = '0;
        endcase
    end

    assign INT_REQ = pending & mie;
    assign MTVEC   = mtvec;
    assign MEPC    = mepc;

endmodule

// File: tb/tb_trap_csr_unit.sv
// tb/tb_trap_csr_unit.sv - directed self-checking bench for trap_csr_unit
module tb_trap_csr_unit;

    logic        clk = 1'b0;
    logic        RST;
    logic        INTR;
    logic [31:0] PC;
    logic        INT_TAKEN;
    logic        MRET;
    logic        CSR_WE;
    logic [11:0] CSR_ADDR;
    logic [31:0] CSR_WD;
    logic [31:0] CSR_RD;
    logic        INT_REQ;
    logic [31:0] MTVEC;
    logic [31:0] MEPC;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    trap_csr_unit dut (
        .clk       (clk),
        .RST       (RST),
        .INTR      (INTR),
        .PC        (PC),
        .INT_TAKEN (INT_TAKEN),
        .MRET      (MRET),
        .CSR_WE    (CSR_WE),
        .CSR_ADDR  (CSR_ADDR),
        .CSR_WD    (CSR_WD),
        .CSR_RD    (CSR_RD),
        .INT_REQ   (INT_REQ),
        .MTVEC     (MTVEC),
        .MEPC      (MEPC)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        CSR_ADDR = addr;
        #1;
        chk(tag, CSR_RD, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        CSR_WE   = 1'b1;
        CSR_ADDR = addr;
        CSR_WD   = data;
    endtask

    task automatic idle();
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET      = 1'b0;
    endtask

    initial begin
        RST = 1'b1; INTR = 1'b1; PC = '0; INT_TAKEN = 1'b0; MRET = 1'b0;
        CSR_WE = 1'b0; CSR_ADDR = '0; CSR_WD = '0;
        @(negedge clk);
        step(); step(); step();

        chk("rst_int_req", {31'b0, INT_REQ}, 32'h0);
        chk("rst_mtvec", MTVEC, 32'h0);
        chk("rst_mepc", MEPC, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mtvec_rd", 12'h305, 32'h0);
        rd("rst_mepc_rd", 12'h341, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);

        RST = 1'b0; INTR = 1'b0;
        step(); step(); step(); step();
        chk("post_rst_int_req", {31'b0, INT_REQ}, 32'h0);

        // CSR writes and reads
        wr(12'h305, 32'h0000_0203);
        #1 chk("rd_old_in_write_cycle", CSR_RD, 32'h0);
        step(); idle();
        rd("mtvec_rd", 12'h305, 32'h0000_0200);
        chk("mtvec_out", MTVEC, 32'h0000_0200);

        wr(12'h300, 32'hFFFF_FFFF); step(); idle();
        rd("mstatus_mask", 12'h300, 32'h0000_0088);
        rd("unimpl_rd", 12'h7C0, 32'h0);
        wr(12'h7C0, 32'hDEAD_BEEF); step(); idle();
        rd("unimpl_after_wr", 12'h7C0, 32'h0);
        wr(12'h342, 32'h1234_5677); step(); idle();
        rd("mcause_full", 12'h342, 32'h1234_5677);
        wr(12'h341, 32'h0000_1003); step(); idle();
        chk("mepc_wr_align", MEPC, 32'h0000_1000);

        // Interrupt latency with MIE=1
        INTR = 1'b1;
        step();
        chk("lat_k", {31'b0, INT_REQ}, 32'h0);
        step();
        chk("lat_k1", {31'b0, INT_REQ}, 32'h0);
        step();
        chk("lat_k2", {31'b0, INT_REQ}, 32'h1);

        // Trap entry and return
        PC = 32'h0000_0123; INT_TAKEN = 1'b1;
        step(); idle();
        chk("trap_mepc", MEPC, 32'h0000_0120);
        rd("trap_mcause", 12'h342, 32'h8000_000B);
        rd("trap_mstatus", 12'h300, 32'h0000_0080);
        chk("trap_int_req", {31'b0, INT_REQ}, 32'h0);
        MRET = 1'b1;
        step(); idle();
        rd("mret_mstatus", 12'h300, 32'h0000_0088);
        step(); step();
        chk("held_high_no_rereq", {31'b0, INT_REQ}, 32'h0);
        INTR = 1'b0;

        // INT_TAKEN with CSR write to mepc: capture wins
        PC = 32'h0000_2007; INT_TAKEN = 1'b1; wr(12'h341, 32'h0000_5554);
        step(); idle();
        chk("sim_mepc_capture", MEPC, 32'h0000_2004);
        rd("sim_mstatus1", 12'h300, 32'h0000_0080);
        // INT_TAKEN with CSR write to mtvec: both apply
        PC = 32'h0000_3000; INT_TAKEN = 1'b1; wr(12'h305, 32'h0000_4001);
        step(); idle();
        chk("sim_mtvec_wr", MTVEC, 32'h0000_4000);
        chk("sim_mepc2", MEPC, 32'h0000_3000);
        rd("sim_mstatus2", 12'h300, 32'h0000_0000);

        // Masked pending
        step(); step();
        INTR = 1'b1;
        step(); step(); step(); step();
        chk("masked_int_req", {31'b0, INT_REQ}, 32'h0);
        wr(12'h300, 32'h0000_0008);
        #1 chk("masked_wr_cycle", {31'b0, INT_REQ}, 32'h0);
        step(); idle();
        chk("unmask_int_req", {31'b0, INT_REQ}, 32'h1);

        // New edge coinciding with INT_TAKEN keeps pending
        INTR = 1'b0;
        step(); step(); step();
        INTR = 1'b1;
        step(); step();
        INT_TAKEN = 1'b1;
        step(); idle();
        chk("edge_taken_int_req", {31'b0, INT_REQ}, 32'h0);
        rd("edge_taken_mstatus", 12'h300, 32'h0000_0080);
        MRET = 1'b1;
        step(); idle();
        chk("edge_taken_pending_kept", {31'b0, INT_REQ}, 32'h1);
        INT_TAKEN = 1'b1;
        step(); idle();
        MRET = 1'b1;
        step(); idle();
        chk("pending_cleared", {31'b0, INT_REQ}, 32'h0);

        // Reset mid-operation drops an edge in the synchronizer
        INTR = 1'b0;
        step(); step(); step();
        INTR = 1'b1;
        step(); step();
        RST = 1'b1; INTR = 1'b0;
        step();
        RST = 1'b0;
        step(); step(); step();
        rd("midrst_mstatus", 12'h300, 32'h0);
        chk("midrst_mtvec", MTVEC, 32'h0);
        wr(12'h300, 32'h0000_0008); step(); idle();
        chk("midrst_edge_lost", {31'b0, INT_REQ}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/trap_csr_unit.md
# trap_csr_unit

Machine-mode trap and CSR unit for the OTTER core: the source end of the program counter's `MTVEC`/`MEPC` trap inputs. It synchronizes the external interrupt line, latches a pending interrupt and raises `INT_REQ` to the control unit when interrupts are enabled. On trap entry and `mret` it updates `mstatus`. It also serves CSR reads and writes for the four implemented CSRs.

## Interface
Parameters:
- `MCAUSE_EXT`, default `32'h8000_000B`, value written to `mcause` on interrupt entry.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `RST` input 1: synchronous reset, active-high.
- `INTR` input 1: external interrupt, asynchronous to `clk`, level; only its rising edge is significant.
- `PC` input 32: current PC value, saved on trap entry.
- `INT_TAKEN` input 1: control unit is entering the trap this cycle (it also drives the PC mux to `MTVEC`).
- `MRET` input 1: `mret` executes this cycle.
- `CSR_WE` input 1: CSR write strobe.
- `CSR_ADDR` input 12: CSR address.
- `CSR_WD` input 32: CSR write data.
- `CSR_RD` output 32: CSR read data, combinational from `CSR_ADDR`.
- `INT_REQ` output 1: `pending & mstatus.MIE`.
- `MTVEC` output 32: trap vector to the PC mux.
- `MEPC` output 32: return address to the PC mux.

## Operation
- **Implemented CSRs**
  - `mstatus` 0x300: only bit 3 `MIE` and bit 7 `MPIE` are stored; all other bits read 0 and ignore writes.
  - `mtvec` 0x305: direct mode; bits[1:0] are forced to 0 on write.
  - `mepc` 0x341: bits[1:0] are forced to 0 on write and on capture.
  - `mcause` 0x342: full 32-bit register.
- **Unimplemented addresses:** reads return 0; writes are ignored.
- **Interrupt path**
  - `INTR` passes through two flops (`s1`, `s2`) and then an edge register `s3`.
  - `edge = s2 & ~s3`.
  - `pending` is set on `edge`. It is cleared only by `INT_TAKEN` or `RST`. Level-high `INTR` does not re-set it.
- **`INT_TAKEN` actions (one cycle):**
  - `mepc <= {PC[31:2],2'b00}`
  - `MPIE <= MIE`
  - `MIE <= 0`
  - `mcause <= MCAUSE_EXT`
  - `pending <= 0`
- **`MRET` actions:** `MIE <= MPIE`, `MPIE <= 1`.
- **Priority, highest first:**
  1. `RST`
  2. `INT_TAKEN`
  3. `MRET`
  4. `CSR_WE`
  - A lower-priority write to a field touched by a higher-priority event is dropped that cycle. Writes to untouched CSRs (e.g. `mtvec`) still take effect.
- **Edge and `INT_TAKEN` in the same cycle:** the new edge wins, so `pending` ends at 1 (the new interrupt is not lost). All other `INT_TAKEN` effects still apply.
- **`INT_TAKEN` while `pending` = 0:** still performs the entry actions; this is the control unit's responsibility.
- **`MTVEC`/`MEPC` outputs:** driven directly from the registers; a write is visible the cycle after the write edge.

## Timing
- **Reset values:** all CSRs 0, `pending` = 0, sync flops 0.
  - Outputs: `INT_REQ` = 0, `MTVEC` = 0, `MEPC` = 0.
  - `CSR_RD` = 0 for every address.
- **Reset mid-operation:** a pending interrupt is discarded, and an `INTR` edge already in the synchronizer is lost.
- **Interrupt latency:** `INTR` sampled high at edge k, low before:
  - `s1` = 1 after edge k.
  - `s2` = 1 after edge k+1.
  - `pending` = 1 after edge k+2.
  - `INT_REQ` rises after edge k+2 when `MIE` = 1.
- **Held pending:** if `MIE` = 0, `pending` holds; `INT_REQ` rises the cycle after `MIE` becomes 1 (CSR write or `MRET`).
- **Read/write:** `CSR_RD` is combinational, with zero latency. A read of a CSR in its write cycle returns the old value.
- **Trap entry:** `INT_TAKEN` at edge n gives `INT_REQ` = 0 after edge n (unless a new edge arrived), and `MEPC` updated after edge n.

## Structure
- **Package `otter_csr_pkg`:**
  - CSR address constants: `CSR_MSTATUS`, `CSR_MTVEC`, `CSR_MEPC`, `CSR_MCAUSE`.
  - Bit indices: `MSTATUS_MIE` = 3, `MSTATUS_MPIE` = 7.
  - Default constant `MCAUSE_EXT_INT`.
- **Sub-module `intr_sync`:** the two-flop synchronizer plus rising-edge detector. It has `clk`/`RST`/async input and a one-cycle pulse output, and is reused for other async inputs.

## Test plan
- **Reset:** assert `RST` with `INTR`=1. Expected: `INT_REQ`=0, `MTVEC`=0, `MEPC`=0, and `CSR_RD`=0 at 0x300/0x305/0x341/0x342.
- **CSR write/read:**
  - Write 0x305←`32'h0000_0203`; read 0x305 → `32'h0000_0200`.
  - Write 0x300←`32'hFFFF_FFFF`; read 0x300 → `32'h0000_0088`.
  - Read 0x7C0 → 0.
- **Interrupt latency:** set `MIE`=1, raise `INTR` at edge k. Expected: `INT_REQ`=0 after edge k+1, then 1 after edge k+2. Holding `INTR` high after `INT_TAKEN` must not re-raise `INT_REQ`.
- **Trap entry/return:**
  - `PC`=`32'h0000_0123`, pulse `INT_TAKEN`. Expected: `MEPC`=`32'h0000_0120`, `mcause`=`32'h8000_000B`, `mstatus`=`32'h80`, `INT_REQ`=0.
  - Then pulse `MRET`. Expected: `mstatus`=`32'h88`.
- **Simultaneous events:**
  - `INT_TAKEN` and `CSR_WE` to 0x341 in the same cycle: the `PC` capture wins. Same pair with a write to 0x305: `mtvec` is updated as well.
  - `INT_TAKEN` coinciding with a new edge: `pending` stays 1.
- **Masked pending:** with `MIE`=0, deliver an edge. Expected: `INT_REQ` stays 0. Then write `mstatus`=8: `INT_REQ`=1 the following cycle.
